phys_free_list: RTL
===================

// Module: phys_free_list
// PURPOSE
//  Circular free list of physical register tags for the R10000-style rename stage.
//  - Supplies up to WIDTH new dest_physical tags per cycle to dispatch.
//  - Reclaims up to WIDTH retire_old tags per cycle from the ROB retire port.
//  - Sits between the ROB retire outputs and the rename/dispatch inputs.
// PARAMETERS
//  PHY_REG_NUM    64  total physical registers
//  ARCH_REG_NUM   32  architectural registers; list depth DEPTH = PHY_REG_NUM-ARCH_REG_NUM
//  PHY_REG_WIDTH   6  physical tag width, equal to $clog2(PHY_REG_NUM)
//  WIDTH           2  superscalar width of the alloc and free ports
// PORTS
//  clock        in   1                    system clock, rising edge
//  reset        in   1                    synchronous, active-low reset
//  alloc_req    in   WIDTH                lane i requests one new tag
//  alloc_valid  out  WIDTH                lane i granted; alloc_tag[i] valid
//  alloc_tag    out  WIDTH*PHY_REG_WIDTH  granted tag per lane
//  alloc_stall  out  1                    request cannot be fully satisfied this cycle
//  free_valid   in   WIDTH                lane i returns free_tag[i] (ROB retire_valid)
//  free_tag     in   WIDTH*PHY_REG_WIDTH  tag being released (ROB retire_old)
//  free_count   out  $clog2(DEPTH+1)      registered count of free entries
//  err          out  1                    sticky: overflow, or double free with macro
// BEHAVIOUR
//  - State: entry array[DEPTH], head ptr, tail ptr, count; ptrs wrap modulo DEPTH.
//  - Reset (reset==0 at posedge):
//    - entry[k] = ARCH_REG_NUM+k; head = tail = 0; count = DEPTH; err = 0.
//    - Reset mid-operation discards all in-flight allocs and frees.
//  - Allocation, combinational from registered state:
//    - n_req = popcount(alloc_req).
//    - grant = (n_req <= count), all-or-nothing.
//    - alloc_stall = (n_req != 0) && !grant.
//    - alloc_valid[i] = alloc_req[i] && grant.
//    - alloc_tag[i] = entry[(head + popcount(alloc_req[i-1:0])) mod DEPTH].
//    - Lanes are compacted: a lone request on lane 1 receives entry[head].
//    - alloc_tag on non-granted lanes is don't-care; the bench must not check it.
//  - On a clock edge with grant: head += n_req (mod DEPTH).
//  - Free: valid lanes are written compacted at tail in lane order; tail += n_free.
//  - Next count = count - (grant ? n_req : 0) + n_free_accepted.
//  - Same-cycle alloc and free:
//    - Freed tags are not visible to allocation until the next cycle.
//    - No bypass, so zero combinational path from free_* to alloc_*.
//  - Overflow:
//    - A free lane that would take count past DEPTH is dropped; later lanes are dropped too.
//    - err is set on the next edge.
//  - count==0: any nonzero request stalls; head is unchanged.
//  - count==DEPTH with tail==head: the list is full; the count disambiguates full from empty.
//  - err stays asserted until reset.
// CONFIGURATION
//  FREELIST_DUP_CHECK_EN defined:
//    - Keep a PHY_REG_NUM-bit in_list vector.
//    - Reset value: bits ARCH_REG_NUM..PHY_REG_NUM-1 set.
//    - Set on accepted free, cleared on grant.
//    - A free of a tag already in_list, or duplicated across lanes in one cycle,
//      is dropped and sets err.
//  FREELIST_DUP_CHECK_EN undefined:
//    - No vector, no check; every free is accepted subject only to overflow.
// TESTING
//  1 Reset, then alloc_req=2'b11 -> alloc_valid=11, tags 32,33; next cycle free_count=30.
//  2 alloc_req=2'b10 only -> alloc_valid=10, alloc_tag[1]=32; free_count 32->31.
//  3 Drain with 16 cycles of 2'b11 -> free_count=0; then alloc_req=01 -> alloc_stall=1, valid=00.
//  4 From empty: free_valid=11, tags 10,11, with alloc_req=11 in the same cycle ->
//    stall that cycle; next cycle tags 10,11 granted.
//  5 Wrap: 20 alloc/free-pair cycles past DEPTH -> tags come back in FIFO order;
//    free_count stays constant.
//  6 Free when full -> err=1, free_count=32; assert reset mid-burst ->
//    state restored, err=0, next tags 32,33.
//  7 With FREELIST_DUP_CHECK_EN: free tag 40 while it is still in the list -> err=1,
//    free_count unchanged.

Source files
------------

// File: rtl/phys_free_list_if.sv
// Rename-stage bundle between dispatch/ROB (master) and the physical-tag free list (slave).
// The free list carries no bypass, so the alloc_* outputs never depend on free_* inputs.
interface phys_free_list_if #(
    parameter int WIDTH         = 2,
    parameter int PHY_REG_WIDTH = 6,
    parameter int CNT_W         = 6
);
    logic [WIDTH-1:0]                    alloc_req;
    logic [WIDTH-1:0]                    alloc_valid;
    logic [WIDTH-1:0][PHY_REG_WIDTH-1:0] alloc_tag;
    logic                                alloc_stall;
    logic [WIDTH-1:0]                    free_valid;
    logic [WIDTH-1:0][PHY_REG_WIDTH-1:0] free_tag;
    logic [CNT_W-1:0]                    free_count;
    logic                                err;

    modport master (
        output alloc_req, free_valid, free_tag,
        input  alloc_valid, alloc_tag, alloc_stall, free_count, err
    );

    modport slave (
        input  alloc_req, free_valid, free_tag,
        output alloc_valid, alloc_tag, alloc_stall, free_count, err
    );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags: WIDTH-wide all-or-nothing allocate, WIDTH-wide free.
// Define FREELIST_DUP_CHECK_EN to track list membership and reject double frees.
module phys_free_list #(
    parameter int PHY_REG_NUM   = 64,
    parameter int ARCH_REG_NUM  = 32,
    parameter int PHY_REG_WIDTH = $clog2(PHY_REG_NUM),
    parameter int WIDTH         = 2
) (
    input logic             clock_i,
    input logic             reset_i,   // synchronous, active-low
    phys_free_list_if.slave fl
);
    localparam int DEPTH = PHY_REG_NUM - ARCH_REG_NUM;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PHY_REG_WIDTH-1:0] tag_t;
    typedef logic [PTR_W-1:0]         ptr_t;
    typedef logic [CNT_W-1:0]         cnt_t;

    tag_t        entry_q [DEPTH];
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        count_q, count_d;
    logic        err_q, err_d;

    logic [WIDTH-1:0] wr_en;
    ptr_t             wr_idx [WIDTH];
    tag_t             wr_tag [WIDTH];

    int unsigned n_req;
    logic        grant;

`ifdef FREELIST_DUP_CHECK_EN
    logic [PHY_REG_NUM-1:0] in_list_q, in_list_d;
`endif

    function automatic ptr_t ptr_add(ptr_t base, int unsigned off);
        return ptr_t'((32'(base) + off) % 32'(DEPTH));
    endfunction

    // Lane i reads the slot after all lower requesting lanes, so requests are compacted.
    always_comb begin
        int unsigned off;
        off          = 0;
        fl.alloc_tag = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fl.alloc_tag[i] = entry_q[ptr_add(head_q, off)];
            off             = off + 32'(fl.alloc_req[i]);
        end
        n_req = off;
    end

    assign grant          = (n_req <= 32'(count_q));
    assign fl.alloc_valid = fl.alloc_req & {WIDTH{grant}};
    assign fl.alloc_stall = (n_req != 0) && !grant;
    assign fl.free_count  = count_q;
    assign fl.err         = err_q;

    always_comb begin
        int unsigned base;
        int unsigned n_acc;
        logic        stop;
`ifdef FREELIST_DUP_CHECK_EN
        logic [PHY_REG_NUM-1:0] seen;
`endif
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        head_d = grant ? ptr_add(head_q, n_req) : head_q;
        err_d  = err_q;
        wr_en  = '0;
        for (int j = 0; j < WIDTH; j++) begin
            wr_idx[j] = '0;
            wr_tag[j] = '0;
        end
        // Overflow is judged against the occupancy left after this cycle's grant.
        base  = grant ? (32'(count_q) - n_req) : 32'(count_q);
        n_acc = 0;
        stop  = 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
        seen      = in_list_q;
        in_list_d = in_list_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (fl.alloc_req[i] && grant) in_list_d[fl.alloc_tag[i]] = 1'b0;
        end
`endif
        for (int j = 0; j < WIDTH; j++) begin
            if (fl.free_valid[j] && !stop) begin
`ifdef FREELIST_DUP_CHECK_EN
                if (seen[fl.free_tag[j]]) begin
                    err_d = 1'b1;
                end else
`endif
                if (base + n_acc >= 32'(DEPTH)) begin
                    stop  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    wr_en[j]  = 1'b1;
                    wr_idx[j] = ptr_add(tail_q, n_acc);
                    wr_tag[j] = fl.free_tag[j];
                    n_acc     = n_acc + 1;
`ifdef FREELIST_DUP_CHECK_EN
                    seen[fl.free_tag[j]]      = 1'b1;
                    in_list_d[fl.free_tag[j]] = 1'b1;
`endif
                end
            end
        end
        tail_d  = ptr_add(tail_q, n_acc);
        count_d = cnt_t'(base + n_acc);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= cnt_t'(DEPTH);
            err_q   <= 1'b0;
            // NOTE: the entry array is reset on purpose: its reset contents are the initial free tags.
            for (int k = 0; k < DEPTH; k++) entry_q[k] <= tag_t'(ARCH_REG_NUM + k);
`ifdef FREELIST_DUP_CHECK_EN
            in_list_q <= {{DEPTH{1'b1}}, {ARCH_REG_NUM{1'b0}}};
`endif
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
            for (int j = 0; j < WIDTH; j++) begin
                if (wr_en[j]) entry_q[wr_idx[j]] <= wr_tag[j];
            end
`ifdef FREELIST_DUP_CHECK_EN
            in_list_q <= in_list_d;
`endif
        end
    end
endmodule
